// File: rtl/yarvi_uart_pkg.sv
// rtl/yarvi_uart_pkg.sv - register map and bit positions for the yarvi UART MMIO block
package yarvi_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int STATUS_RX_NONEMPTY = 0;
    localparam int STATUS_TX_FULL     = 1;
    localparam int STATUS_TX_EMPTY    = 2;
    localparam int STATUS_TX_DROP     = 3;

    localparam int CTRL_RX_IRQ_EN     = 0;

endpackage

// File: rtl/yarvi_byte_fifo.sv
// rtl/yarvi_byte_fifo.sv - byte FIFO of 2**FIFO_LOG2 entries with head-of-queue output
module yarvi_byte_fifo #(
    parameter int FIFO_LOG2 = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int                   DEPTH_INT = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]   DEPTH     = DEPTH_INT[FIFO_LOG2:0];
    localparam logic [FIFO_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [FIFO_LOG2:0]   CNT_ONE   = 1;

    logic [7:0]           mem_q [DEPTH_INT];
    logic [7:0]           mem_d [DEPTH_INT];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]   count_q, count_d;
    logic                 do_push, do_pop;

    // Flags come from registered occupancy, so a same-cycle pop never frees room
    // for a push and a same-cycle push never feeds a pop.
    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head is only meaningful while the FIFO is nonempty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/yarvi_uart_mmio.sv
// rtl/yarvi_uart_mmio.sv - memory-mapped UART byte bridge; YARVI_UART_IRQ_EN enables the RX interrupt
module yarvi_uart_mmio
    import yarvi_uart_pkg::*;
#(
    parameter int FIFO_LOG2 = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        irq
);

    logic        rd_req, wr_req;
    logic        rx_pop, tx_push;
    logic        rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0]  rx_head;
    logic [31:0] status_word, ctrl_word;
    logic [31:0] rdata_d, rdata_q;
    logic        rvalid_d, rvalid_q;
    logic        tx_drop_d, tx_drop_q;
    logic        rx_irq_en;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^bus_wdata[31:8];

    always_comb begin
        rd_req  = bus_req & ~bus_we;
        wr_req  = bus_req & bus_we;
        rx_pop  = rd_req && (bus_addr == REG_DATA);
        tx_push = wr_req && (bus_addr == REG_DATA);
    end

    yarvi_byte_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head)
    );

    yarvi_byte_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (bus_wdata[7:0]),
        .pop       (tx_ready),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_data)
    );

    assign rx_ready = ~rx_full;
    assign tx_valid = ~tx_empty;

    always_comb begin
        status_word                     = '0;
        status_word[STATUS_RX_NONEMPTY] = ~rx_empty;
        status_word[STATUS_TX_FULL]     = tx_full;
        status_word[STATUS_TX_EMPTY]    = tx_empty;
        status_word[STATUS_TX_DROP]     = tx_drop_q;
        ctrl_word                       = '0;
        ctrl_word[CTRL_RX_IRQ_EN]       = rx_irq_en;

        rvalid_d = rd_req;
        rdata_d  = '0;
        if (rd_req) begin
            case (bus_addr)
                REG_DATA:   rdata_d = rx_empty ? 32'h0 : {1'b1, 23'b0, rx_head};
                REG_STATUS: rdata_d = status_word;
                REG_CTRL:   rdata_d = ctrl_word;
                default:    rdata_d = '0;
            endcase
        end

        // A drop in the same cycle as a software clear leaves the flag set.
        tx_drop_d = tx_drop_q;
        if (wr_req && (bus_addr == REG_STATUS) && bus_wdata[STATUS_TX_DROP]) begin
            tx_drop_d = 1'b0;
        end
        if (tx_push && tx_full) begin
            tx_drop_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            tx_drop_q <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            tx_drop_q <= tx_drop_d;
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;

`ifdef YARVI_UART_IRQ_EN
    logic rx_irq_en_d, rx_irq_en_q;
    logic irq_d, irq_q;

    always_comb begin
        rx_irq_en_d = rx_irq_en_q;
        if (wr_req && (bus_addr == REG_CTRL)) begin
            rx_irq_en_d = bus_wdata[CTRL_RX_IRQ_EN];
        end
        irq_d = rx_irq_en_q & ~rx_empty;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_irq_en_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            rx_irq_en_q <= rx_irq_en_d;
            irq_q       <= irq_d;
        end
    end

    assign rx_irq_en = rx_irq_en_q;
    assign irq       = irq_q;
`else
    assign rx_irq_en = 1'b0;
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_yarvi_uart_mmio.sv
// tb/tb_yarvi_uart_mmio.sv - scoreboard bench for yarvi_uart_mmio (honours YARVI_UART_IRQ_EN)
module tb_yarvi_uart_mmio;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [1:0]  bus_addr = 2'd0;
    logic [31:0] bus_wdata = 32'h0;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  rx_data = 8'h0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_rd_q [$];
    logic [7:0]  exp_tx_q [$];

    yarvi_uart_mmio #(.FIFO_LOG2(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .irq        (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: read responses and TX handshakes are checked against the queues.
    always @(negedge clock) begin
        if (bus_rvalid === 1'b1) begin
            if (exp_rd_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rvalid: got rdata 0x%08h expected no response", bus_rdata);
            end else begin
                check("bus_rdata", bus_rdata, exp_rd_q.pop_front());
            end
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (exp_tx_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_tx: got 0x%02h expected no byte", tx_data);
            end else begin
                check("tx_data_stream", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic peek(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
        check(name, act_sel, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        next_cycle();
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] b, input bit expect_out);
        if (expect_out) exp_tx_q.push_back(b);
        bus_write(2'd0, {24'h0, b});
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
        exp_rd_q.push_back(exp);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
        next_cycle();
        bus_req = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        next_cycle();
        rx_valid = 1'b0;
    endtask

    task automatic drain_tx();
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && exp_tx_q.size() != 0; i++) @(posedge clock);
        #1;
        check("tx_drain_complete", exp_tx_q.size(), 0);
        #3;
        check("tx_valid_after_drain", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish within 100000 ns");
        $fatal(1);
    end

    initial begin
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #3;
        check("reset_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("reset_rvalid", {31'h0, bus_rvalid}, 32'h0);
        check("reset_rdata", bus_rdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        next_cycle();

        // Two bytes out with the link stalled, then released in order.
        tx_write(8'h41, 1'b1);
        tx_write(8'h42, 1'b1);
        #3;
        check("tx_valid_held", {31'h0, tx_valid}, 32'h1);
        check("tx_data_held0", {24'h0, tx_data}, 32'h41);
        next_cycle();
        next_cycle();
        #3;
        check("tx_data_held1", {24'h0, tx_data}, 32'h41);
        drain_tx();

        // Overfill TX: ninth byte dropped, sticky flag set then cleared.
        for (int i = 0; i < 9; i++) tx_write(8'(i), i < 8);
        bus_read(2'd1, 32'h0000_000A);
        drain_tx();
        bus_read(2'd1, 32'h0000_000C);
        bus_write(2'd1, 32'h0000_0008);
        bus_read(2'd1, 32'h0000_0004);

        // Fill RX with no reads; ninth byte must wait for room.
        for (int i = 0; i < 8; i++) begin
            #3;
            check("rx_ready_filling", {31'h0, rx_ready}, 32'h1);
            rx_send(8'h10 + 8'(i));
        end
        #3;
        check("rx_ready_full", {31'h0, rx_ready}, 32'h0);
        rx_valid = 1'b1; rx_data = 8'h18;
        next_cycle();
        #3;
        check("rx_ready_held", {31'h0, rx_ready}, 32'h0);
        bus_read(2'd0, 32'h8000_0010);
        #3;
        check("rx_ready_after_pop", {31'h0, rx_ready}, 32'h1);
        next_cycle();
        rx_valid = 1'b0;
        for (int i = 1; i < 9; i++) bus_read(2'd0, 32'h8000_0010 + 32'(i));
        bus_read(2'd0, 32'h0);
        bus_read(2'd1, 32'h0000_0004);
        bus_read(2'd0, 32'h0);
        check("irq_disabled", {31'h0, irq}, 32'h0);

        // Receive interrupt.
        bus_write(2'd2, 32'h1);
`ifdef YARVI_UART_IRQ_EN
        bus_read(2'd2, 32'h1);
        rx_send(8'h55);
        #3;
        check("irq_lag", {31'h0, irq}, 32'h0);
        next_cycle();
        #3;
        check("irq_set", {31'h0, irq}, 32'h1);
        bus_read(2'd0, 32'h8000_0055);
        #3;
        check("irq_after_pop", {31'h0, irq}, 32'h1);
        next_cycle();
        #3;
        check("irq_cleared", {31'h0, irq}, 32'h0);
`else
        bus_read(2'd2, 32'h0);
        rx_send(8'h55);
        #3;
        check("irq_off0", {31'h0, irq}, 32'h0);
        next_cycle();
        #3;
        check("irq_off1", {31'h0, irq}, 32'h0);
        bus_read(2'd0, 32'h8000_0055);
        #3;
        check("irq_off2", {31'h0, irq}, 32'h0);
`endif

        // Reserved address.
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, 32'h0);
        bus_read(2'd1, 32'h0000_0004);

        // Reset with bytes buffered in both directions discards them.
        tx_write(8'hA1, 1'b0);
        tx_write(8'hA2, 1'b0);
        rx_send(8'hB1);
        bus_write(2'd1, 32'h0);
        do_reset();
        #3;
        check("midreset_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("midreset_rx_ready", {31'h0, rx_ready}, 32'h1);
        bus_read(2'd1, 32'h0000_0004);
        bus_read(2'd0, 32'h0);
        bus_read(2'd2, 32'h0);

        next_cycle();
        next_cycle();
        check("rd_queue_empty", exp_rd_q.size(), 0);
        check("tx_queue_empty", exp_tx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
